// File: rtl/vscale_htif_pcr_master.sv
// HTIF-side master for the CSR file's PCR port: forwards host CSR commands and
// periodically polls the to_host CSR, surfacing non-zero values on a separate handshake.
module vscale_htif_pcr_master #(
    parameter int          POLL_INTERVAL = 16,
    parameter logic [11:0] TOHOST_ADDR   = 12'h780
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        poll_enable,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic        host_req_rw,
    input  logic [11:0] host_req_addr,
    input  logic [63:0] host_req_data,
    output logic        host_resp_valid,
    input  logic        host_resp_ready,
    output logic [63:0] host_resp_data,
    output logic        tohost_valid,
    input  logic        tohost_ready,
    output logic [63:0] tohost_data,
    output logic        pcr_req_valid,
    input  logic        pcr_req_ready,
    output logic        pcr_req_rw,
    output logic [11:0] pcr_req_addr,
    output logic [63:0] pcr_req_data,
    input  logic        pcr_resp_valid,
    output logic        pcr_resp_ready,
    input  logic [63:0] pcr_resp_data,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a valid, once raised, holds its payload stable until that transfer.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_HRESP = 2'd3
    } state_t;

    localparam logic [15:0] RELOAD = 16'(POLL_INTERVAL - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic        txn_host;
    logic        poll_due;
    logic        launch_poll;
    logic        host_accept;
    logic        resp_fire;

    assign poll_due    = (count == 16'd0) && poll_enable && !tohost_valid;
    assign launch_poll = (state == S_IDLE) && poll_due;
    assign host_accept = (state == S_IDLE) && !poll_due && host_req_valid;
    assign resp_fire   = (state == S_RESP) && pcr_resp_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (poll_due || host_req_valid) state_next = S_REQ;
            S_REQ:   if (pcr_req_ready) state_next = S_RESP;
            S_RESP:  if (pcr_resp_valid) state_next = txn_host ? S_HRESP : S_IDLE;
            S_HRESP: if (host_resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Polls pre-empt host commands; reset_n gating keeps ready low while held in reset.
    assign host_req_ready  = reset_n && (state == S_IDLE) && !poll_due;
    assign pcr_req_valid   = (state == S_REQ);
    assign pcr_resp_ready  = (state == S_RESP);
    assign host_resp_valid = (state == S_HRESP);
    assign dbg_state       = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count          <= RELOAD;
            txn_host       <= 1'b0;
            pcr_req_rw     <= 1'b0;
            pcr_req_addr   <= 12'd0;
            pcr_req_data   <= 64'd0;
            host_resp_data <= 64'd0;
            tohost_valid   <= 1'b0;
            tohost_data    <= 64'd0;
        end else begin
            // The counter keeps running through REQ/RESP so the poll period is independent
            // of PCR latency; it only freezes while a to_host value is waiting.
            if (!poll_enable || launch_poll) begin
                count <= RELOAD;
            end else if (!tohost_valid && count != 16'd0) begin
                count <= count - 16'd1;
            end

            if (launch_poll) begin
                pcr_req_rw   <= 1'b0;
                pcr_req_addr <= TOHOST_ADDR;
                pcr_req_data <= 64'd0;
                txn_host     <= 1'b0;
            end else if (host_accept) begin
                pcr_req_rw   <= host_req_rw;
                pcr_req_addr <= host_req_addr;
                pcr_req_data <= host_req_data;
                txn_host     <= 1'b1;
            end

            if (tohost_valid && tohost_ready) begin
                tohost_valid <= 1'b0;
            end

            if (resp_fire) begin
                if (txn_host) begin
                    host_resp_data <= pcr_resp_data;
                end else if (pcr_resp_data != 64'd0) begin
                    tohost_data  <= pcr_resp_data;
                    tohost_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vscale_htif_pcr_master.sv
// Bench for vscale_htif_pcr_master: directed timing cases followed by randomized traffic,
// with a CSR-file model on the PCR port and a scoreboard on the host and to_host outputs.
module tb_vscale_htif_pcr_master;

    localparam int          PI = 4;
    localparam logic [11:0] TH = 12'h780;

    logic        clk;
    logic        reset_n;
    logic        poll_enable;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_rw;
    logic [11:0] host_req_addr;
    logic [63:0] host_req_data;
    logic        host_resp_valid;
    logic        host_resp_ready;
    logic [63:0] host_resp_data;
    logic        tohost_valid;
    logic        tohost_ready;
    logic [63:0] tohost_data;
    logic        pcr_req_valid;
    logic        pcr_req_ready;
    logic        pcr_req_rw;
    logic [11:0] pcr_req_addr;
    logic [63:0] pcr_req_data;
    logic        pcr_resp_valid;
    logic        pcr_resp_ready;
    logic [63:0] pcr_resp_data;
    logic [1:0]  dbg_state;

    vscale_htif_pcr_master #(.POLL_INTERVAL(PI), .TOHOST_ADDR(TH)) dut (
        .clk(clk), .reset_n(reset_n), .poll_enable(poll_enable),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_rw(host_req_rw), .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
        .host_resp_data(host_resp_data),
        .tohost_valid(tohost_valid), .tohost_ready(tohost_ready), .tohost_data(tohost_data),
        .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready),
        .pcr_req_rw(pcr_req_rw), .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
        .pcr_resp_valid(pcr_resp_valid), .pcr_resp_ready(pcr_resp_ready),
        .pcr_resp_data(pcr_resp_data), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] tohost_q[$];
    logic [63:0] csr_mem[4096];
    logic [63:0] ref_mem[4096];
    bit          host_inflight = 0;
    logic        acc_rw;
    logic [11:0] acc_addr;
    logic [63:0] acc_data;
    int          host_done_cnt = 0;
    int          poll_cnt = 0;
    bit          slave_en = 1;
    bit          slave_rand = 0;
    int          resp_mode = 0;
    int          th_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // ---------------- output consumers ----------------
    initial begin
        host_resp_ready = 1'b0;
        tohost_ready    = 1'b0;
        forever begin
            @(negedge clk);
            host_resp_ready = ready_pick(resp_mode);
            tohost_ready    = ready_pick(th_mode);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit          prev_hold;
        bit          prev_th_hold;
        logic [63:0] prev_data;
        logic [63:0] prev_th;
        prev_hold    = 0;
        prev_th_hold = 0;
        prev_data    = '0;
        prev_th      = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n) begin
                if (prev_hold) begin
                    chk("resp_hold_valid", 64'(host_resp_valid), 64'd1);
                    chk("resp_hold_data", host_resp_data, prev_data);
                end
                if (prev_th_hold) begin
                    chk("tohost_hold_valid", 64'(tohost_valid), 64'd1);
                    chk("tohost_hold_data", tohost_data, prev_th);
                end
                if (host_resp_valid && host_resp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL host_resp_unexpected: got %0h expected none", host_resp_data);
                    end else begin
                        chk("host_resp_data", host_resp_data, exp_q.pop_front());
                    end
                    host_done_cnt++;
                end
                if (tohost_valid && tohost_ready) begin
                    if (tohost_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tohost_unexpected: got %0h expected none", tohost_data);
                    end else begin
                        chk("tohost_data", tohost_data, tohost_q.pop_front());
                    end
                end
                prev_hold    = host_resp_valid && !host_resp_ready;
                prev_data    = host_resp_data;
                prev_th_hold = tohost_valid && !tohost_ready;
                prev_th      = tohost_data;
            end else begin
                prev_hold    = 0;
                prev_th_hold = 0;
            end
        end
    end

    // ---------------- CSR file model on the PCR port ----------------
    initial begin
        logic [63:0] v;
        bit          is_host;
        int          d;
        pcr_req_ready  = 1'b0;
        pcr_resp_valid = 1'b0;
        pcr_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (!slave_en) begin
                pcr_req_ready = 1'b0;
                continue;
            end
            pcr_req_ready = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            if (pcr_req_valid && pcr_req_ready) begin
                is_host = host_inflight;
                if (is_host) begin
                    chk("pcr_host_rw", 64'(pcr_req_rw), 64'(acc_rw));
                    chk("pcr_host_addr", 64'(pcr_req_addr), 64'(acc_addr));
                    chk("pcr_host_data", pcr_req_data, acc_data);
                    host_inflight = 0;
                end else begin
                    chk("poll_rw", 64'(pcr_req_rw), 64'd0);
                    chk("poll_addr", 64'(pcr_req_addr), 64'(TH));
                    chk("poll_data", pcr_req_data, 64'd0);
                    chk("poll_while_tohost", 64'(tohost_valid), 64'd0);
                    poll_cnt++;
                    if (ref_mem[TH] != 64'd0) tohost_q.push_back(ref_mem[TH]);
                end
                v = csr_mem[pcr_req_addr];
                if (pcr_req_rw) csr_mem[pcr_req_addr] = pcr_req_data;
                d = slave_rand ? $urandom_range(1, 4) : 1;
                @(negedge clk);
                pcr_req_ready = 1'b0;
                repeat (d - 1) @(negedge clk);
                pcr_resp_valid = 1'b1;
                pcr_resp_data  = v;
                #2;
                chk("pcr_resp_ready", 64'(pcr_resp_ready), 64'd1);
                @(negedge clk);
                pcr_resp_valid = 1'b0;
                pcr_resp_data  = {$urandom, $urandom};
                #2;
                if (is_host) begin
                    chk("host_resp_latency", 64'(host_resp_valid), 64'd1);
                end else begin
                    chk("tohost_after_poll", 64'(tohost_valid), 64'(v != 64'd0));
                    if (v != 64'd0) chk("tohost_capture", tohost_data, v);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_resp(input int done0);
        int n;
        n = 0;
        while (host_done_cnt == done0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (host_done_cnt == done0) begin
            checks++;
            errors++;
            $display("FAIL host_resp_timeout: got no response expected one");
        end
    endtask

    task automatic host_txn(input logic rw, input logic [11:0] addr, input logic [63:0] data,
                            input bit wait_done);
        bit acc;
        int done0;
        host_req_rw    = rw;
        host_req_addr  = addr;
        host_req_data  = data;
        host_req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 400 && !acc; i++) begin
            #1;
            if (host_req_ready) acc = 1;
            else @(negedge clk);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL host_accept_timeout: got ready=0 expected ready=1");
            host_req_valid = 1'b0;
            return;
        end
        exp_q.push_back(ref_mem[addr]);
        if (rw) ref_mem[addr] = data;
        acc_rw        = rw;
        acc_addr      = addr;
        acc_data      = data;
        host_inflight = 1;
        done0         = host_done_cnt;
        @(negedge clk);
        host_req_valid = 1'b0;
        #2;
        chk("req_latency", 64'(pcr_req_valid), 64'd1);
        if (wait_done) wait_resp(done0);
    endtask

    task automatic wait_req_rise(output int n);
        bit prev;
        prev = pcr_req_valid;
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            #2;
            if (pcr_req_valid && !prev) begin
                n = i;
                return;
            end
            prev = pcr_req_valid;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        int          cnt;
        int          done0;
        int          polls0;
        bit          found;
        logic [63:0] v;
        logic [11:0] a;
        logic        rw;

        for (int i = 0; i < 4096; i++) begin
            v = {$urandom, $urandom};
            csr_mem[i] = v;
            ref_mem[i] = v;
        end
        csr_mem[TH] = '0;
        ref_mem[TH] = '0;
        reset_n        = 1'b0;
        poll_enable    = 1'b0;
        host_req_valid = 1'b0;
        host_req_rw    = 1'b0;
        host_req_addr  = '0;
        host_req_data  = '0;

        // reset state
        repeat (3) @(negedge clk);
        #2;
        chk("reset_valids_readys",
            64'({host_req_ready, pcr_req_valid, pcr_resp_ready, host_resp_valid, tohost_valid}), 64'd0);
        chk("reset_data_outs", host_resp_data | tohost_data | pcr_req_data, 64'd0);
        chk("reset_req_fields", 64'({pcr_req_rw, pcr_req_addr}), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk("ready_after_reset", 64'(host_req_ready), 64'd1);

        // host write 0x781 <- 0x5A, then read it back
        @(negedge clk);
        host_txn(1'b1, 12'h781, 64'h5A, 1);
        host_txn(1'b0, 12'h781, 64'h0, 1);

        // first poll latency and non-zero to_host capture/hold
        csr_mem[TH] = 64'h1;
        ref_mem[TH] = 64'h1;
        th_mode = 2;
        @(negedge clk);
        poll_enable = 1'b1;
        wait_req_rise(n);
        chk("poll_first_delay", 64'(n), 64'd4);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            found = tohost_valid;
        end
        chk("tohost_seen", 64'(found), 64'd1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            #2;
            if (pcr_req_valid) cnt++;
        end
        chk("no_poll_while_tohost", 64'(cnt), 64'd0);
        csr_mem[TH] = '0;
        ref_mem[TH] = '0;
        th_mode = 0;

        // zero polls: period and no output
        wait_req_rise(n);
        chk("poll_resume", 64'(n > 0), 64'd1);
        wait_req_rise(n);
        chk("poll_gap_a", 64'(n), 64'd4);
        wait_req_rise(n);
        chk("poll_gap_b", 64'(n), 64'd4);
        chk("zero_poll_no_tohost", 64'(tohost_valid), 64'd0);

        // poll wins against a simultaneous host request
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            found = (dbg_state == 2'd0) && !host_req_ready;
        end
        chk("poll_due_seen", 64'(found), 64'd1);
        polls0 = poll_cnt;
        host_txn(1'b0, 12'h300, 64'h0, 1);
        chk("poll_won_arbitration", 64'(poll_cnt > polls0), 64'd1);

        // host response back-pressure
        resp_mode = 2;
        done0 = host_done_cnt;
        host_txn(1'b0, 12'h781, 64'h0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            found = host_resp_valid;
        end
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            #2;
            if (pcr_req_valid) cnt++;
        end
        chk("no_pcr_during_hresp", 64'(cnt), 64'd0);
        chk("hresp_still_valid", 64'(host_resp_valid), 64'd1);
        resp_mode = 0;
        wait_resp(done0);

        // reset while in REQ abandons the transaction
        poll_enable = 1'b0;
        repeat (10) @(negedge clk);
        slave_en = 0;
        host_txn(1'b0, 12'h301, 64'h0, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_drops_req", 64'(pcr_req_valid), 64'd0);
        chk("reset_state_idle", 64'(dbg_state), 64'd0);
        void'(exp_q.pop_back());
        host_inflight = 0;
        poll_enable = 1'b1;
        @(negedge clk);
        reset_n  = 1'b1;
        slave_en = 1;
        #2;
        chk("idle_after_reset", 64'(dbg_state), 64'd0);
        wait_req_rise(n);
        chk("counter_reloaded", 64'(n), 64'd4);

        // randomized traffic
        slave_rand = 1;
        resp_mode  = 1;
        th_mode    = 1;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) == 0) poll_enable = ~poll_enable;
            case ($urandom_range(0, 3))
                0:       a = TH;
                1:       a = 12'h781;
                2:       a = 12'h300 + 12'($urandom_range(0, 3));
                default: a = 12'($urandom_range(0, 4095));
            endcase
            rw = 1'($urandom_range(0, 1));
            v  = (a == TH && $urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            host_txn(rw, a, v, 1);
        end

        // drain
        poll_enable = 1'b0;
        resp_mode   = 0;
        th_mode     = 0;
        repeat (30) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("tohost_q_drained", 64'(tohost_q.size()), 64'd0);
        chk("polls_seen", 64'(poll_cnt > 0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vscale_htif_pcr_master.md
VSCALE_HTIF_PCR_MASTER -- requirements
Module: vscale_htif_pcr_master

Interface
REQ-001 Parameter POLL_INTERVAL, default 16, cycles between to_host polls; legal range 1..65535.
REQ-002 Parameter TOHOST_ADDR, default 12'h780, CSR address polled for to_host.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 poll_enable  input  1  enables periodic to_host polling.
REQ-006 host_req_valid / host_req_ready  input / output  1 / 1  host command handshake.
REQ-007 host_req_rw  input  1  1 = write, 0 = read.
REQ-008 host_req_addr  input  12  target CSR address.
REQ-009 host_req_data  input  64  write data.
REQ-010 host_resp_valid / host_resp_ready  output / input  1 / 1  host response handshake.
REQ-011 host_resp_data  output  64  PCR read data (write responses return the PCR response data unchanged).
REQ-012 tohost_valid / tohost_ready  output / input  1 / 1  handshake for non-zero to_host values found by polling.
REQ-013 tohost_data  output  64  captured to_host value.
REQ-014 pcr_req_valid / pcr_req_ready  output / input  1 / 1  handshake to the CSR file's HTIF PCR port.
REQ-015 pcr_req_rw  output  1  request type.
REQ-016 pcr_req_addr  output  12  request address.
REQ-017 pcr_req_data  output  64  request write data.
REQ-018 pcr_resp_valid / pcr_resp_ready  input / output  1 / 1  PCR response handshake.
REQ-019 pcr_resp_data  input  64  PCR response data.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, RESP and HRESP; only one PCR transaction may be outstanding.
REQ-021 Poll counter: 16-bit down-counter.
- Loads POLL_INTERVAL-1 on reset, when poll_enable=0, and when a poll is issued.
- Decrements in any state while poll_enable=1, tohost_valid=0 and the count is non-zero.
- poll_due = (count==0) & poll_enable & !tohost_valid.
REQ-022 IDLE arbitration:
- If poll_due: launch poll (rw=0, addr=TOHOST_ADDR, data=0), go to REQ; host_req_ready=0.
- Else host_req_ready=1; on host_req_valid, register rw/addr/data, set txn_host=1, go to REQ.
REQ-023 REQ: pcr_req_valid=1 with the registered fields held stable; go to RESP on the cycle pcr_req_ready=1.
REQ-024 RESP: pcr_resp_ready=1.
- On pcr_resp_valid with txn_host=1: capture pcr_resp_data into host_resp_data and go to HRESP.
- On pcr_resp_valid with txn_host=0: if data!=0, load tohost_data and set tohost_valid; return to IDLE.
REQ-025 HRESP: host_resp_valid=1; go to IDLE on host_resp_ready.
REQ-026 tohost_valid SHALL stay set until tohost_ready=1; while it is set, no poll is issued, but host requests are still served.
REQ-027 Latency:
- Host request accepted in cycle N: pcr_req_valid in N+1.
- PCR response in cycle M: host_resp_valid in M+1; earliest next host_req_ready in cycle M+2.
REQ-028 A zero poll result SHALL produce no output and no state change other than the counter reload.
REQ-029 A host access to TOHOST_ADDR SHALL pass through as an ordinary host transaction and SHALL NOT set tohost_valid.
REQ-030 If poll_enable deasserts mid-poll, the outstanding poll SHALL still complete normally.
REQ-031 All outputs SHALL be driven from registers or from FSM state only; there are no combinational paths from inputs to outputs except host_req_ready's dependence on poll_due.

Reset
REQ-032 On reset_n=0, asynchronously:
- FSM goes to IDLE.
- All valid and ready outputs go to 0 (host_req_ready follows IDLE/poll_due once reset is released).
- All data outputs go to 0; the counter goes to POLL_INTERVAL-1; txn_host goes to 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction without emitting any response.

Verification
REQ-034 Host write 0x781 data 0x5A with pcr_req_ready=1 and response one cycle later -> pcr_req_valid one cycle after acceptance carrying rw=1, addr=0x781, data=0x5A; host_resp_valid follows.
REQ-035 poll_enable=1, POLL_INTERVAL=4, PCR returns 0x1 -> poll request at addr 0x780 issued 4 cycles after enable; tohost_valid=1 with tohost_data=0x1; no further polls until tohost_ready.
REQ-036 Poll due and host_req_valid asserted in the same cycle -> poll wins, host_req_ready=0; host request accepted after the poll completes.
REQ-037 PCR returns 0 for a poll -> tohost_valid stays 0; next poll follows 4 cycles later.
REQ-038 host_resp_ready held low 10 cycles -> host_resp_valid and host_resp_data stable throughout; no new PCR request issued.
REQ-039 reset_n pulsed low while in REQ -> pcr_req_valid drops immediately; after release the FSM is in IDLE and the counter is reloaded.
